// File: rtl/retire_stage.sv
// Retire stage: commits up to three instructions per cycle (slot 2 oldest), updates the
// architectural map table, releases old physical tags and raises recovery or halt.
module retire_stage #(
  parameter int ARCH_REGS = 32,
  parameter int PREG_W    = 6,
  parameter int XLEN      = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [2:0]                        rt_valid,
  input  logic [2:0][4:0]                   rt_dest,
  input  logic [2:0][PREG_W-1:0]            rt_tag,
  input  logic [2:0][PREG_W-1:0]            rt_told,
  input  logic [2:0]                        rt_precise,
  input  logic [2:0][XLEN-1:0]              rt_pc,
  input  logic [2:0]                        rt_store,
  input  logic [2:0]                        rt_halt,
  output logic [2:0]                        sq_retire,
  output logic [2:0]                        fl_rel_valid,
  output logic [2:0][PREG_W-1:0]            fl_rel_tag,
  output logic                              rec_enable,
  output logic [XLEN-1:0]                   rec_pc,
  output logic [ARCH_REGS-1:0][PREG_W-1:0]  amt_out,
  output logic [31:0]                       retire_cnt,
  output logic                              halted
);

  typedef enum logic [1:0] {RUN, RECOVER, HALT} state_t;

  state_t                            state;
  logic [ARCH_REGS-1:0][PREG_W-1:0]  amt;
  logic [2:0]                        effective;
  logic                              blocked;
  logic                              halt_hit;
  logic                              precise_hit;
  logic [XLEN-1:0]                   hit_pc;
  logic [1:0]                        retire_inc;

  // Walk oldest to youngest; the first precise or halt slot retires and blocks everything younger.
  always_comb begin
    effective   = '0;
    blocked     = (state != RUN);
    halt_hit    = 1'b0;
    precise_hit = 1'b0;
    hit_pc      = '0;
    for (int i = 2; i >= 0; i--) begin
      if (!blocked && rt_valid[i]) begin
        effective[i] = 1'b1;
        if (rt_precise[i] || rt_halt[i]) begin
          blocked     = 1'b1;
          halt_hit    = rt_halt[i];
          precise_hit = rt_precise[i] & ~rt_halt[i];
          hit_pc      = rt_pc[i];
        end
      end
    end
    retire_inc = {1'b0, effective[0]} + {1'b0, effective[1]} + {1'b0, effective[2]};
  end

  assign sq_retire = rst ? 3'b000 : (effective & rt_store);
  assign amt_out   = amt;

  // Slots are applied oldest first so the youngest writer of a shared dest wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ARCH_REGS; i++) amt[i] <= PREG_W'(i);
      retire_cnt   <= '0;
      state        <= RUN;
      fl_rel_valid <= '0;
      fl_rel_tag   <= '0;
      rec_enable   <= 1'b0;
      rec_pc       <= '0;
      halted       <= 1'b0;
    end else begin
      fl_rel_valid <= '0;
      fl_rel_tag   <= '0;
      rec_enable   <= 1'b0;
      rec_pc       <= '0;
      for (int i = 2; i >= 0; i--) begin
        if (effective[i] && rt_dest[i] != 5'd0) begin
          amt[rt_dest[i]] <= rt_tag[i];
          fl_rel_valid[i] <= 1'b1;
          fl_rel_tag[i]   <= rt_told[i];
        end
      end
      retire_cnt <= retire_cnt + 32'(retire_inc);
      case (state)
        RUN: begin
          if (halt_hit) begin
            state  <= HALT;
            halted <= 1'b1;
          end else if (precise_hit) begin
            state      <= RECOVER;
            rec_enable <= 1'b1;
            rec_pc     <= hit_pc;
          end
        end
        RECOVER: state <= RUN;
        HALT:    state <= HALT;
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_retire_stage.sv
// Directed self-checking bench for retire_stage; expected values are hand-computed per scenario.
module tb_retire_stage;

  localparam int PREG_W = 6;
  localparam int XLEN   = 32;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [2:0]               rt_valid;
  logic [2:0][4:0]          rt_dest;
  logic [2:0][PREG_W-1:0]   rt_tag;
  logic [2:0][PREG_W-1:0]   rt_told;
  logic [2:0]               rt_precise;
  logic [2:0][XLEN-1:0]     rt_pc;
  logic [2:0]               rt_store;
  logic [2:0]               rt_halt;
  logic [2:0]               sq_retire;
  logic [2:0]               fl_rel_valid;
  logic [2:0][PREG_W-1:0]   fl_rel_tag;
  logic                     rec_enable;
  logic [XLEN-1:0]          rec_pc;
  logic [31:0][PREG_W-1:0]  amt_out;
  logic [31:0]              retire_cnt;
  logic                     halted;

  int pass_cnt  = 0;
  int total_cnt = 0;

  retire_stage #(.ARCH_REGS(32), .PREG_W(PREG_W), .XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .rt_valid(rt_valid), .rt_dest(rt_dest), .rt_tag(rt_tag),
    .rt_told(rt_told), .rt_precise(rt_precise), .rt_pc(rt_pc), .rt_store(rt_store),
    .rt_halt(rt_halt), .sq_retire(sq_retire), .fl_rel_valid(fl_rel_valid),
    .fl_rel_tag(fl_rel_tag), .rec_enable(rec_enable), .rec_pc(rec_pc),
    .amt_out(amt_out), .retire_cnt(retire_cnt), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rt_valid = '0; rt_dest = '0; rt_tag = '0; rt_told = '0;
    rt_precise = '0; rt_pc = '0; rt_store = '0; rt_halt = '0;
  endtask

  task automatic set_slot(input int s, input logic [4:0] dest, input logic [PREG_W-1:0] tag,
                          input logic [PREG_W-1:0] told, input logic precise,
                          input logic [XLEN-1:0] pc, input logic store, input logic halt);
    rt_valid[s] = 1'b1; rt_dest[s] = dest; rt_tag[s] = tag; rt_told[s] = told;
    rt_precise[s] = precise; rt_pc[s] = pc; rt_store[s] = store; rt_halt[s] = halt;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    else pass_cnt++;
  endtask

  task automatic check_amt_identity(input string name);
    int bad = -1;
    total_cnt++;
    for (int i = 0; i < 32; i++) if (amt_out[i] !== PREG_W'(i) && bad < 0) bad = i;
    if (bad >= 0) $display("[TB] FAIL %s: amt[%0d] got %0d expected %0d", name, bad, amt_out[bad], bad);
    else pass_cnt++;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cnt"}, retire_cnt, 32'd0);
    check({tag, "_halted"}, 32'(halted), 32'd0);
    check({tag, "_rec_en"}, 32'(rec_enable), 32'd0);
    check({tag, "_rec_pc"}, rec_pc, 32'd0);
    check({tag, "_fl_valid"}, 32'(fl_rel_valid), 32'd0);
    check_amt_identity({tag, "_amt"});
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    set_slot(2, 5'd3, 6'd33, 6'd3, 1'b0, 32'h0, 1'b1, 1'b0);
    #1;
    check("rst_sq_retire", 32'(sq_retire), 32'd0);
    step();
    step();
    rst = 1'b0;
    clear_inputs();
    check_reset_outputs("reset");
  endtask

  task automatic test_three_retires();
    clear_inputs();
    set_slot(2, 5'd5, 6'd40, 6'd5, 1'b0, 32'h0, 1'b0, 1'b0);
    set_slot(1, 5'd6, 6'd41, 6'd6, 1'b0, 32'h0, 1'b0, 1'b0);
    set_slot(0, 5'd0, 6'd42, 6'd0, 1'b0, 32'h0, 1'b0, 1'b0);
    step();
    clear_inputs();
    check("three_amt5", 32'(amt_out[5]), 32'd40);
    check("three_amt6", 32'(amt_out[6]), 32'd41);
    check("three_amt0", 32'(amt_out[0]), 32'd0);
    check("three_fl_valid", 32'(fl_rel_valid), 32'b110);
    check("three_fl_tag2", 32'(fl_rel_tag[2]), 32'd5);
    check("three_fl_tag1", 32'(fl_rel_tag[1]), 32'd6);
    check("three_cnt", retire_cnt, 32'd3);
    step();
    check("idle_fl_valid", 32'(fl_rel_valid), 32'd0);
  endtask

  task automatic test_same_dest();
    clear_inputs();
    set_slot(2, 5'd7, 6'd50, 6'd7, 1'b0, 32'h0, 1'b0, 1'b0);
    set_slot(1, 5'd7, 6'd51, 6'd50, 1'b0, 32'h0, 1'b0, 1'b0);
    step();
    clear_inputs();
    check("same_amt7", 32'(amt_out[7]), 32'd51);
    check("same_fl_valid", 32'(fl_rel_valid), 32'b110);
    check("same_fl_tag2", 32'(fl_rel_tag[2]), 32'd7);
    check("same_fl_tag1", 32'(fl_rel_tag[1]), 32'd50);
    check("same_cnt", retire_cnt, 32'd5);
  endtask

  task automatic test_precise();
    clear_inputs();
    set_slot(2, 5'd8, 6'd52, 6'd8, 1'b0, 32'h0, 1'b1, 1'b0);
    set_slot(1, 5'd9, 6'd53, 6'd9, 1'b1, 32'h100, 1'b1, 1'b0);
    set_slot(0, 5'd10, 6'd54, 6'd10, 1'b0, 32'h0, 1'b1, 1'b0);
    #1;
    check("prec_sq_retire", 32'(sq_retire), 32'b110);
    step();
    check("prec_rec_en", 32'(rec_enable), 32'd1);
    check("prec_rec_pc", rec_pc, 32'h100);
    check("prec_amt8", 32'(amt_out[8]), 32'd52);
    check("prec_amt9", 32'(amt_out[9]), 32'd53);
    check("prec_amt10", 32'(amt_out[10]), 32'd10);
    check("prec_fl_valid", 32'(fl_rel_valid), 32'b110);
    check("prec_cnt", retire_cnt, 32'd7);
    clear_inputs();
    set_slot(2, 5'd11, 6'd55, 6'd11, 1'b0, 32'h0, 1'b1, 1'b0);
    #1;
    check("recover_sq_retire", 32'(sq_retire), 32'd0);
    step();
    check("recover_rec_en", 32'(rec_enable), 32'd0);
    check("recover_rec_pc", rec_pc, 32'd0);
    check("recover_amt11", 32'(amt_out[11]), 32'd11);
    check("recover_cnt", retire_cnt, 32'd7);
    check("recover_fl_valid", 32'(fl_rel_valid), 32'd0);
    #1;
    check("run_sq_retire", 32'(sq_retire), 32'b100);
    step();
    clear_inputs();
    check("run_amt11", 32'(amt_out[11]), 32'd55);
    check("run_cnt", retire_cnt, 32'd8);
  endtask

  task automatic test_halt();
    clear_inputs();
    set_slot(2, 5'd12, 6'd56, 6'd12, 1'b1, 32'h300, 1'b1, 1'b1);
    set_slot(1, 5'd13, 6'd57, 6'd13, 1'b0, 32'h0, 1'b1, 1'b0);
    set_slot(0, 5'd14, 6'd58, 6'd14, 1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    check("halt_sq_retire", 32'(sq_retire), 32'b100);
    step();
    check("halt_halted", 32'(halted), 32'd1);
    check("halt_rec_en", 32'(rec_enable), 32'd0);
    check("halt_amt12", 32'(amt_out[12]), 32'd56);
    check("halt_amt13", 32'(amt_out[13]), 32'd13);
    check("halt_cnt", retire_cnt, 32'd9);
    check("halt_fl_valid", 32'(fl_rel_valid), 32'b100);
    check("halt_fl_tag2", 32'(fl_rel_tag[2]), 32'd12);
    clear_inputs();
    set_slot(2, 5'd15, 6'd59, 6'd15, 1'b0, 32'h0, 1'b1, 1'b0);
    #1;
    check("halted_sq_retire", 32'(sq_retire), 32'd0);
    step();
    step();
    check("halted_amt15", 32'(amt_out[15]), 32'd15);
    check("halted_cnt", retire_cnt, 32'd9);
    check("halted_sticky", 32'(halted), 32'd1);
    check("halted_fl_valid", 32'(fl_rel_valid), 32'd0);
  endtask

  task automatic test_reset_in_progress();
    // Still halted from the previous scenario, with a valid retire presented during rst.
    rst = 1'b1;
    step();
    rst = 1'b0;
    clear_inputs();
    check_reset_outputs("rst_halt");
    set_slot(2, 5'd4, 6'd60, 6'd4, 1'b1, 32'h200, 1'b0, 1'b0);
    step();
    check("rst_rec_setup", 32'(rec_enable), 32'd1);
    clear_inputs();
    rst = 1'b1;
    set_slot(2, 5'd16, 6'd61, 6'd16, 1'b0, 32'h0, 1'b0, 1'b0);
    step();
    rst = 1'b0;
    clear_inputs();
    check_reset_outputs("rst_recover");
    set_slot(1, 5'd17, 6'd62, 6'd17, 1'b0, 32'h0, 1'b0, 1'b0);
    step();
    clear_inputs();
    check("post_rst_amt17", 32'(amt_out[17]), 32'd62);
    check("post_rst_cnt", retire_cnt, 32'd1);
  endtask

  task automatic test_wrap();
    clear_inputs();
    force dut.retire_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.retire_cnt;
    check("wrap_preload", retire_cnt, 32'hFFFF_FFFF);
    set_slot(0, 5'd0, 6'd0, 6'd0, 1'b0, 32'h0, 1'b0, 1'b0);
    step();
    clear_inputs();
    check("wrap_cnt", retire_cnt, 32'd0);
    check("wrap_fl_valid", 32'(fl_rel_valid), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_three_retires();
    test_same_dest();
    test_precise();
    test_halt();
    test_reset_in_progress();
    test_wrap();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
